// File: rtl/cell_tester.sv
// cell_tester: on-chip stimulus/response engine for a single standard cell.
// Applies every input vector in turn, waits a programmable settle time, samples
// the synchronized cell output and compares it with a Wishbone-loaded truth table.
//
// Wishbone handshake: a transfer is requested while stb&cyc are high with a
// matching address; ack is returned one cycle later for exactly one cycle, the
// master holds stb/cyc/we/adr/dat/sel until it sees ack, writes take effect at
// the end of the ack cycle, and read data is valid only while ack is high.
module cell_tester #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  stim_o,
  output logic        stim_en_o,
  input  logic        resp_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  // Configuration and truth table (frozen while a run is active)
  logic [1:0]  nin_m1;
  logic [7:0]  settle;
  logic [15:0] truth;

  // Run state and status
  logic        busy;
  logic        done;
  logic        pass;
  logic        aborted;
  logic [3:0]  first_fail;
  logic [4:0]  errcnt;
  logic [15:0] capture;
  logic [3:0]  idx;
  logic [8:0]  cnt;

  // Response synchronizer
  logic        resp_q1;
  logic        resp_s;

  // Bus decode
  logic        sel_hit;
  logic        wr_en;
  logic [1:0]  reg_sel;
  logic        ctrl_wr;
  logic        truth_wr;
  logic        running;
  logic        start_req;
  logic        abort_req;
  logic [3:0]  last_idx;
  logic [15:0] cap_mask;
  logic [31:0] rdata;

  logic        unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_dat_i[7:6],
                         wbs_dat_i[3:2], wbs_sel_i[3:2]};

  assign sel_hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_en     = wbs_ack_o & sel_hit & wbs_we_i;
  assign ctrl_wr   = wr_en & (reg_sel == 2'd0);
  assign truth_wr  = wr_en & (reg_sel == 2'd1);
  assign running   = (state != S_IDLE);
  // ABORT in the same write suppresses START
  assign start_req = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0] & ~wbs_dat_i[1] & ~running;
  assign abort_req = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[1] & running;

  // Last vector index and valid capture bits for the configured input count
  always_comb begin
    last_idx = 4'd15;
    cap_mask = 16'hFFFF;
    case (nin_m1)
      2'd0:    begin last_idx = 4'd1; cap_mask = 16'h0003; end
      2'd1:    begin last_idx = 4'd3; cap_mask = 16'h000F; end
      2'd2:    begin last_idx = 4'd7; cap_mask = 16'h00FF; end
      default: begin last_idx = 4'd15; cap_mask = 16'hFFFF; end
    endcase
  end

  // Ack one cycle after a matching request, never two cycles in a row
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
    end else begin
      wbs_ack_o <= sel_hit & ~wbs_ack_o;
    end
  end

  // Two-flop synchronizer for the asynchronous cell output
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      resp_q1 <= 1'b0;
      resp_s  <= 1'b0;
    end else begin
      resp_q1 <= resp_i;
      resp_s  <= resp_q1;
    end
  end

  // Configuration registers, byte-lane writes accepted only while idle
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      nin_m1 <= 2'd0;
      settle <= 8'd0;
      truth  <= 16'd0;
    end else if (!running) begin
      if (ctrl_wr) begin
        if (wbs_sel_i[0]) nin_m1 <= wbs_dat_i[5:4];
        if (wbs_sel_i[1]) settle <= wbs_dat_i[15:8];
      end
      if (truth_wr) begin
        if (wbs_sel_i[0]) truth[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) truth[15:8] <= wbs_dat_i[15:8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; abort overrides every active state
  always_comb begin
    state_next = state;
    if (abort_req) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_req) state_next = S_APPLY;
        S_APPLY:  state_next = S_WAIT;
        S_WAIT:   if (cnt == 9'd1) state_next = S_SAMPLE;
        S_SAMPLE: state_next = (idx == last_idx) ? S_DONE : S_APPLY;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Run datapath: vector index, settle counter, capture and error bookkeeping
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      aborted    <= 1'b0;
      first_fail <= 4'd0;
      errcnt     <= 5'd0;
      capture    <= 16'd0;
      idx        <= 4'd0;
      cnt        <= 9'd0;
      stim_o     <= 4'd0;
    end else if (abort_req) begin
      busy    <= 1'b0;
      aborted <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
      stim_o  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            aborted <= 1'b0;
            errcnt  <= 5'd0;
            capture <= 16'd0;
            idx     <= 4'd0;
          end
        end
        S_APPLY: begin
          busy   <= 1'b1;
          stim_o <= idx;
          cnt    <= {1'b0, settle} + 9'd2;
        end
        S_WAIT: begin
          cnt <= cnt - 9'd1;
        end
        S_SAMPLE: begin
          capture[idx] <= resp_s;
          if (resp_s != truth[idx]) begin
            errcnt <= errcnt + 5'd1;
            if (errcnt == 5'd0) first_fail <= idx;
          end
          if (idx != last_idx) idx <= idx + 4'd1;
        end
        S_DONE: begin
          done   <= 1'b1;
          pass   <= (errcnt == 5'd0);
          busy   <= 1'b0;
          stim_o <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  // Output decode: completion pulse, driver enable, read mux
  always_comb begin
    irq_o     = (state == S_DONE);
    stim_en_o = busy;
    rdata     = 32'd0;
    if (wbs_ack_o) begin
      case (reg_sel)
        2'd0: begin
          rdata[5:4]  = nin_m1;
          rdata[15:8] = settle;
        end
        2'd1:    rdata[15:0] = truth;
        2'd2:    rdata = {19'd0, errcnt, first_fail, aborted, pass, done, busy};
        default: rdata[15:0] = capture & cap_mask;
      endcase
    end
    wbs_dat_o = rdata;
  end

endmodule

// File: tb/tb_cell_tester.sv
// Bench for cell_tester: models several cells on resp_i, runs a table of
// configurations and a few hand-written multi-cycle sequences.
module tb_cell_tester;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_TRUTH = BASE + 32'h4;
  localparam logic [31:0] A_STATUS = BASE + 32'h8;
  localparam logic [31:0] A_CAP = BASE + 32'hC;

  localparam int F_AND2 = 0, F_XOR2 = 2, F_ONE = 3, F_ZERO = 4,
                 F_BUF = 5, F_PAR = 6, F_AND4 = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat = 32'd0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [3:0]  stim;
  logic        stim_en;
  logic        resp;
  logic        irq;

  cell_tester #(.BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .stim_o(stim), .stim_en_o(stim_en), .resp_i(resp), .irq_o(irq)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Cell model: combinational function, optionally seen through two register
  // stages (new output appears in the third cycle after an input change)
  int   func_mode = F_AND2;
  logic lat_mode = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0;

  function automatic logic cell_f(input int f, input logic [3:0] s);
    case (f)
      F_AND2:  return s[0] & s[1];
      F_XOR2:  return s[0] ^ s[1];
      F_ONE:   return 1'b1;
      F_ZERO:  return 1'b0;
      F_BUF:   return s[0];
      F_PAR:   return ^s;
      F_AND4:  return &s;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    d1 <= cell_f(func_mode, stim);
    d2 <= d1;
  end
  assign resp = lat_mode ? d2 : cell_f(func_mode, stim);

  // Output monitors, sampled on the falling edge
  int irq_count = 0, irq_cyc = 0, en_cnt = 0;
  always @(negedge clk) begin
    if (irq) begin
      irq_count <= irq_count + 1;
      irq_cyc   <= cyc_cnt;
    end
    if (stim_en) en_cnt <= en_cnt + 1;
  end

  // Checking and scoreboard
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=0x%0h expected=<empty queue>", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Wishbone driver: hold the request until ack, release after the ack cycle
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic ok, output int ack_c);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = 4'hF;
    ok = 1'b0; rd = 32'd0; ack_c = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ok = 1'b1; ack_c = cyc_cnt; rd = rdat_o;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d,
                          output int ack_c);
    logic [31:0] rd;
    logic ok;
    wb_access(1'b1, a, d, rd, ok, ack_c);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s write ack timeout addr=0x%0h", name, a);
    end
  endtask

  task automatic wb_read(input string name, input logic [31:0] a, output logic [31:0] rd);
    logic ok;
    int ack_c;
    wb_access(1'b0, a, 32'd0, rd, ok, ack_c);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s read ack timeout addr=0x%0h", name, a);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] rd;
    check({tag, "_stim"}, {28'd0, stim}, 32'd0);
    check({tag, "_stim_en"}, {31'd0, stim_en}, 32'd0);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    wb_read(tag, A_CTRL, rd);   check({tag, "_ctrl"}, rd, 32'd0);
    wb_read(tag, A_TRUTH, rd);  check({tag, "_truth"}, rd, 32'd0);
    wb_read(tag, A_STATUS, rd); check({tag, "_status"}, rd, 32'd0);
    wb_read(tag, A_CAP, rd);    check({tag, "_capture"}, rd, 32'd0);
  endtask

  // Start a run, wait for the irq and check its timing and the enable window
  task automatic run_and_time(input string name, input logic [1:0] nin_m1,
                              input logic [7:0] settle, output int c);
    int n_vec, per, irq0, en0;
    n_vec = 1 << (int'(nin_m1) + 1);
    per   = int'(settle) + 4;
    irq0  = irq_count;
    en0   = en_cnt;
    wb_write(name, A_CTRL, {16'd0, settle, 2'b00, nin_m1, 4'b0001}, c);
    for (int i = 0; i < n_vec * per + 40 && irq_count == irq0; i++) @(negedge clk);
    wait_cycles(3);
    check({name, "_irq_count"}, irq_count - irq0, 1);
    check({name, "_irq_cycle"}, irq_cyc, c + 1 + n_vec * per);
    check({name, "_en_cycles"}, en_cnt - en0, n_vec * per);
  endtask

  typedef struct {
    string       name;
    int          func;
    logic        lat;
    logic [1:0]  nin_m1;
    logic [7:0]  settle;
    logic [15:0] truth;
    logic [31:0] exp_status;
    logic [31:0] exp_cap;
  } vec_t;

  vec_t tbl[7];

  initial begin : main
    logic [31:0] rd;
    int c, c2, ack_total, prev_ack, back2back, irq0;
    logic ok;

    // STATUS: [12:8] errcnt, [7:4] first_fail, 3 aborted, 2 pass, 1 done, 0 busy
    tbl[0] = '{"buf1",      F_BUF,  1'b0, 2'd0, 8'd1, 16'h0002, 32'h0006, 32'h0002};
    tbl[1] = '{"and2",      F_AND2, 1'b0, 2'd1, 8'd0, 16'h0008, 32'h0006, 32'h0008};
    tbl[2] = '{"xor2_s2",   F_XOR2, 1'b1, 2'd1, 8'd2, 16'h0006, 32'h0006, 32'h0006};
    tbl[3] = '{"xor2_s0",   F_XOR2, 1'b1, 2'd1, 8'd0, 16'h0006, 32'h0212, 32'h000C};
    tbl[4] = '{"nand3_sa1", F_ONE,  1'b0, 2'd2, 8'd5, 16'h007F, 32'h0172, 32'h00FF};
    tbl[5] = '{"and4_t0",   F_AND4, 1'b0, 2'd3, 8'd3, 16'h0000, 32'h01F2, 32'h8000};
    tbl[6] = '{"sa0_t1",    F_ZERO, 1'b0, 2'd3, 8'd0, 16'hFFFF, 32'h1002, 32'h0000};

    // Reset
    rst_n = 1'b0;
    wait_cycles(4);
    rst_n = 1'b1;
    check_all_zero("reset");

    // Table-driven runs
    foreach (tbl[k]) begin
      func_mode = tbl[k].func;
      lat_mode  = tbl[k].lat;
      wb_write(tbl[k].name, A_TRUTH, {16'd0, tbl[k].truth}, c2);
      exp_q.push_back(tbl[k].exp_status);
      exp_q.push_back(tbl[k].exp_cap);
      run_and_time(tbl[k].name, tbl[k].nin_m1, tbl[k].settle, c);
      wb_read(tbl[k].name, A_STATUS, rd); sb_check({tbl[k].name, "_status"}, rd);
      wb_read(tbl[k].name, A_CAP, rd);    sb_check({tbl[k].name, "_capture"}, rd);
    end

    // Mid-run TRUTH write and second START are ignored
    func_mode = F_AND2; lat_mode = 1'b0;
    wb_write("midrun", A_TRUTH, 32'h0008, c2);
    exp_q.push_back(32'h0006);
    exp_q.push_back(32'h0008);
    exp_q.push_back(32'h0008);
    exp_q.push_back(32'h0010);
    irq0 = irq_count;
    wb_write("midrun", A_CTRL, 32'h0000_0011, c);
    wb_write("midrun_truth", A_TRUTH, 32'h0000, c2);
    wb_write("midrun_start", A_CTRL, 32'h0000_0301, c2);
    for (int i = 0; i < 60 && irq_count == irq0; i++) @(negedge clk);
    wait_cycles(2);
    check("midrun_irq_count", irq_count - irq0, 1);
    check("midrun_irq_cycle", irq_cyc, c + 17);
    wb_read("midrun", A_STATUS, rd); sb_check("midrun_status", rd);
    wb_read("midrun", A_CAP, rd);    sb_check("midrun_capture", rd);
    wb_read("midrun", A_TRUTH, rd);  sb_check("midrun_truth_kept", rd);
    wb_read("midrun", A_CTRL, rd);   sb_check("midrun_ctrl_kept", rd);

    // Abort during vector 6 of a long run
    func_mode = F_PAR;
    wb_write("abort", A_TRUTH, 32'h6996, c2);
    irq0 = irq_count;
    wb_write("abort", A_CTRL, 32'h0000_FF31, c);
    ok = 1'b0;
    for (int i = 0; i < 6 * 259 + 50 && !ok; i++) begin
      @(negedge clk);
      if (stim_en && stim == 4'd6) ok = 1'b1;
    end
    check("abort_reached_vec6", {31'd0, ok}, 32'd1);
    wait_cycles(20);
    wb_write("abort", A_CTRL, 32'h0000_FF32, c2);
    check("abort_stim", {28'd0, stim}, 32'd0);
    check("abort_stim_en", {31'd0, stim_en}, 32'd0);
    wait_cycles(300);
    check("abort_no_irq", irq_count - irq0, 0);
    exp_q.push_back(32'h0008);
    exp_q.push_back(32'h0016);
    wb_read("abort", A_STATUS, rd); sb_check("abort_status", rd);
    wb_read("abort", A_CAP, rd);    sb_check("abort_capture", rd);

    // ABORT while idle, then START+ABORT together: neither changes anything
    wb_write("abort_idle", A_CTRL, 32'h0000_0012, c2);
    wb_write("start_abort", A_CTRL, 32'h0000_0013, c2);
    wait_cycles(10);
    check("start_abort_no_run", {31'd0, stim_en}, 32'd0);
    exp_q.push_back(32'h0008);
    wb_read("start_abort", A_STATUS, rd); sb_check("start_abort_status", rd);

    // Reset in the middle of a run
    func_mode = F_AND2;
    wb_write("rst_mid", A_TRUTH, 32'h0008, c2);
    wb_write("rst_mid", A_CTRL, 32'h0000_0011, c);
    wait_cycles(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("rst_mid");

    // Back-to-back requests: ack every other cycle
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_STATUS; sel = 4'hF;
    ack_total = 0; prev_ack = 0; back2back = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ack_total++;
        if (prev_ack != 0) back2back++;
      end
      prev_ack = int'(ack);
    end
    stb = 1'b0; cyc = 1'b0;
    check("b2b_ack_count", ack_total, 5);
    check("b2b_consecutive", back2back, 0);

    // Non-matching address: no ack and no side effect
    wb_access(1'b1, BASE + 32'h10, 32'h0000_0011, rd, ok, c2);
    check("nomatch_no_ack", {31'd0, ok}, 32'd0);
    wait_cycles(4);
    check("nomatch_no_run", {31'd0, stim_en}, 32'd0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
